// File: rtl/game_state_ctrl.sv
// Match sequencer: drives the shared state bus, both scores, the match countdown and the post-point hold.
// Define GAME_TIMER_EN to build the countdown; without it time_left is tied to 0 and matches end only on score.
module game_state_ctrl #(
   parameter int CLK_PER_SEC  = 100_000_000,
   parameter int GAME_SECONDS = 60,
   parameter int WIN_SCORE    = 5,
   parameter int PAUSE_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_enter,
   input  logic       p1_point,
   input  logic       p2_point,
   output logic [2:0] state,
   output logic [3:0] p1_score,
   output logic [3:0] p2_score,
   output logic [6:0] time_left
);

   localparam logic [2:0] ST_MENU  = 3'b000;
   localparam logic [2:0] ST_GAME  = 3'b001;
   localparam logic [2:0] ST_P1WIN = 3'b010;
   localparam logic [2:0] ST_P2WIN = 3'b011;
   localparam logic [2:0] ST_TIE   = 3'b100;
   localparam logic [2:0] ST_PIONT = 3'b101;
   localparam int PW = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;

   logic [2:0]    state_r, next_state_s;
   logic [3:0]    p1_r, p2_r, p1_next_s, p2_next_s, p1_inc_s, p2_inc_s;
   logic [PW-1:0] pause_r, pause_next_s;
   logic          key_d_r, start_s, any_point_s, win1_s, win2_s, timeout_s;

   function automatic logic [3:0] sat_inc(input logic [3:0] s);
      return (s == 4'd15) ? 4'd15 : s + 4'd1;
   endfunction

   assign start_s     = key_enter & ~key_d_r;
   assign any_point_s = p1_point | p2_point;
   assign p1_inc_s    = p1_point ? sat_inc(p1_r) : p1_r;
   assign p2_inc_s    = p2_point ? sat_inc(p2_r) : p2_r;
   assign win1_s      = (p1_inc_s >= 4'(WIN_SCORE));
   assign win2_s      = (p2_inc_s >= 4'(WIN_SCORE));

`ifdef GAME_TIMER_EN
   localparam int CW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
   logic [CW-1:0] pre_r, pre_next_s;
   logic [6:0]    tl_r, tl_next_s;

   assign timeout_s = (tl_r == 7'd0);

   // Prescaler and seconds countdown; only advances on idle GAME cycles
   always_comb begin
      pre_next_s = pre_r;
      tl_next_s  = tl_r;
      if (next_state_s == ST_MENU) begin
         pre_next_s = {CW{1'b0}};
         tl_next_s  = 7'(GAME_SECONDS);
      end else if (state_r == ST_GAME && !any_point_s && !timeout_s) begin
         if (pre_r == CW'(CLK_PER_SEC - 1)) begin
            pre_next_s = {CW{1'b0}};
            tl_next_s  = (tl_r == 7'd0) ? 7'd0 : tl_r - 7'd1;
         end else begin
            pre_next_s = pre_r + CW'(1);
         end
      end else begin
         pre_next_s = pre_r;
      end
   end

   // Countdown registers
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_r <= {CW{1'b0}};
         tl_r  <= 7'(GAME_SECONDS);
      end else begin
         pre_r <= pre_next_s;
         tl_r  <= tl_next_s;
      end
   end

   // Countdown output
   always_comb begin
      time_left = tl_r;
   end
`else
   assign timeout_s = 1'b0;

   // Countdown not built
   always_comb begin
      time_left = 7'd0;
   end
`endif

   // State, score and pause registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_MENU;
         p1_r    <= 4'd0;
         p2_r    <= 4'd0;
         pause_r <= {PW{1'b0}};
         key_d_r <= 1'b0;
      end else begin
         state_r <= next_state_s;
         p1_r    <= p1_next_s;
         p2_r    <= p2_next_s;
         pause_r <= pause_next_s;
         key_d_r <= key_enter;
      end
   end

   // Next-state and score update; a point outranks a timeout in the same cycle
   always_comb begin
      next_state_s = state_r;
      p1_next_s    = p1_r;
      p2_next_s    = p2_r;
      pause_next_s = pause_r;
      case (state_r)
         ST_MENU: begin
            p1_next_s    = 4'd0;
            p2_next_s    = 4'd0;
            pause_next_s = {PW{1'b0}};
            if (start_s) begin
               next_state_s = ST_GAME;
            end else begin
               next_state_s = ST_MENU;
            end
         end
         ST_GAME: begin
            if (any_point_s) begin
               p1_next_s = p1_inc_s;
               p2_next_s = p2_inc_s;
               if (win1_s && win2_s) begin
                  next_state_s = ST_TIE;
               end else if (win1_s) begin
                  next_state_s = ST_P1WIN;
               end else if (win2_s) begin
                  next_state_s = ST_P2WIN;
               end else begin
                  next_state_s = ST_PIONT;
                  pause_next_s = PW'(PAUSE_CYCLES - 1);
               end
            end else if (timeout_s) begin
               if (p1_r > p2_r) begin
                  next_state_s = ST_P1WIN;
               end else if (p2_r > p1_r) begin
                  next_state_s = ST_P2WIN;
               end else begin
                  next_state_s = ST_TIE;
               end
            end else begin
               next_state_s = ST_GAME;
            end
         end
         ST_PIONT: begin
            if (pause_r == {PW{1'b0}}) begin
               next_state_s = ST_GAME;
            end else begin
               pause_next_s = pause_r - PW'(1);
            end
         end
         ST_P1WIN, ST_P2WIN, ST_TIE: begin
            if (start_s) begin
               next_state_s = ST_MENU;
               p1_next_s    = 4'd0;
               p2_next_s    = 4'd0;
            end else begin
               next_state_s = state_r;
            end
         end
         default: begin
            next_state_s = ST_MENU;
            p1_next_s    = 4'd0;
            p2_next_s    = 4'd0;
            pause_next_s = {PW{1'b0}};
         end
      endcase
   end

   // Outputs come straight from registers
   always_comb begin
      state    = state_r;
      p1_score = p1_r;
      p2_score = p2_r;
   end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboard bench for game_state_ctrl: a behavioural model pushes the expected outputs for every
// driven cycle; they are popped and compared one clock later. Honours GAME_TIMER_EN like the design.
module tb_game_state_ctrl;

   localparam int CPS = 4, GS = 3, WS = 3, PC = 2;
   localparam logic [2:0] MENU = 3'd0, GAME = 3'd1, P1WIN = 3'd2, P2WIN = 3'd3, TIE = 3'd4, PIONT = 3'd5;

   logic       clk = 1'b0;
   logic       rst = 1'b0, key_enter = 1'b0, p1_point = 1'b0, p2_point = 1'b0;
   logic [2:0] state;
   logic [3:0] p1_score, p2_score;
   logic [6:0] time_left;

   typedef struct packed {
      logic [2:0] st;
      logic [3:0] s1;
      logic [3:0] s2;
      logic [6:0] tl;
   } exp_t;
   exp_t sb_q[$];

   int checks = 0, failures = 0;
   logic [2:0] m_state;
   int m_p1, m_p2, m_tl, m_pre, m_pause;
   logic m_kd;

   game_state_ctrl #(.CLK_PER_SEC(CPS), .GAME_SECONDS(GS), .WIN_SCORE(WS), .PAUSE_CYCLES(PC)) dut (
      .clk(clk), .rst(rst), .key_enter(key_enter), .p1_point(p1_point), .p2_point(p2_point),
      .state(state), .p1_score(p1_score), .p2_score(p2_score), .time_left(time_left)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int tl_init();
`ifdef GAME_TIMER_EN
      return GS;
`else
      return 0;
`endif
   endfunction

   task automatic model_clear();
      m_p1 = 0; m_p2 = 0; m_tl = tl_init(); m_pre = 0; m_pause = 0;
   endtask

   // Behavioural model of one clock edge
   task automatic model_step(input logic r, input logic k, input logic a, input logic b);
      logic start;
      logic w1, w2;
      start = k && !m_kd;
      if (r) begin
         m_state = MENU; model_clear(); m_kd = 1'b0;
         return;
      end
      m_kd = k;
      if (m_state == MENU) begin
         model_clear();
         if (start) m_state = GAME;
      end else if (m_state == GAME) begin
         if (a || b) begin
            if (a && m_p1 < 15) m_p1++;
            if (b && m_p2 < 15) m_p2++;
            w1 = (m_p1 >= WS);
            w2 = (m_p2 >= WS);
            if (w1 && w2) m_state = TIE;
            else if (w1) m_state = P1WIN;
            else if (w2) m_state = P2WIN;
            else begin m_state = PIONT; m_pause = PC - 1; end
`ifdef GAME_TIMER_EN
         end else if (m_tl == 0) begin
            m_state = (m_p1 > m_p2) ? P1WIN : (m_p2 > m_p1) ? P2WIN : TIE;
         end else begin
            m_pre++;
            if (m_pre == CPS) begin
               m_pre = 0;
               m_tl--;
            end
`endif
         end
      end else if (m_state == PIONT) begin
         if (m_pause == 0) m_state = GAME;
         else m_pause--;
      end else begin
         if (start) begin m_state = MENU; model_clear(); end
      end
   endtask

   // Drive one cycle, push the model's prediction, then pop and compare after the edge
   task automatic cycle(input logic r, input logic k, input logic a, input logic b);
      exp_t e;
      @(negedge clk);
      rst = r; key_enter = k; p1_point = a; p2_point = b;
      model_step(r, k, a, b);
      e.st = m_state; e.s1 = 4'(m_p1); e.s2 = 4'(m_p2); e.tl = 7'(m_tl);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check_eq("state", 32'(state), 32'(e.st));
      check_eq("p1_score", 32'(p1_score), 32'(e.s1));
      check_eq("p2_score", 32'(p2_score), 32'(e.s2));
      check_eq("time_left", 32'(time_left), 32'(e.tl));
   endtask

   task automatic press();
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Score one point then sit out the hold
   task automatic point(input logic a, input logic b);
      cycle(1'b0, 1'b0, a, b);
      idle(PC);
   endtask

   initial begin
      int n_trans;
      logic [2:0] prev;
      logic k;
      m_state = MENU; m_kd = 1'b0; model_clear();

      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("reset_state", 32'(state), 32'(MENU));
      check_eq("reset_tl", 32'(time_left), 32'(tl_init()));

      // Held key gives exactly one start
      n_trans = 0;
      prev = state;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 1'b0);
         if (state == GAME && prev == MENU) n_trans++;
         prev = state;
      end
      check_eq("start_once", 32'(n_trans), 32'd1);

      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      check_eq("point_to_piont", 32'(state), 32'(PIONT));
      check_eq("point_p1", 32'(p1_score), 32'd1);
      idle(1);
      check_eq("pause_holds", 32'(state), 32'(PIONT));
      idle(1);
      check_eq("pause_ends", 32'(state), 32'(GAME));
      idle(20);
`ifdef GAME_TIMER_EN
      check_eq("timeout_p1win", 32'(state), 32'(P1WIN));
`else
      check_eq("no_timeout", 32'(state), 32'(GAME));
      check_eq("tl_tied", 32'(time_left), 32'd0);
`endif

      // Simultaneous points at 2:2 give a tie
      rst_and_start();
      point(1'b1, 1'b0); point(1'b1, 1'b0); point(1'b0, 1'b1); point(1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      check_eq("tie_state", 32'(state), 32'(TIE));
      check_eq("tie_p1", 32'(p1_score), 32'd3);
      check_eq("tie_p2", 32'(p2_score), 32'd3);
      press();
      check_eq("tie_to_menu", 32'(state), 32'(MENU));
      press();

      // Win on score, points ignored on the end screen, start clears
      point(1'b1, 1'b0); point(1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      check_eq("p1win_state", 32'(state), 32'(P1WIN));
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("p1win_frozen", 32'(p2_score), 32'd0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      check_eq("win_to_menu", 32'(state), 32'(MENU));
      check_eq("win_clear_p1", 32'(p1_score), 32'd0);

      // Reset in the middle of a hold
      press();
      point(1'b1, 1'b0); point(1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("rst_mid_pause", 32'(state), 32'(MENU));
      check_eq("rst_scores", 32'({p1_score, p2_score}), 32'd0);

      // Timeout with P2 ahead
      press();
      point(1'b0, 1'b1);
      idle(20);
`ifdef GAME_TIMER_EN
      check_eq("timeout_p2win", 32'(state), 32'(P2WIN));
`else
      check_eq("no_timeout_p2", 32'(state), 32'(GAME));
`endif

      // Random traffic, fully scoreboarded
      k = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 4) == 0) k = ~k;
         cycle(($urandom_range(0, 99) == 0), k, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   task automatic rst_and_start();
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      press();
   endtask

endmodule
